signal_conditioner: RTL
=======================

# signal_conditioner

Parametrised multi-channel conditioning stage for slow single-bit control and status signals. It generalises a fixed single-signal register hop to NumChannels independent lanes, each with a configurable Depth-stage delay. Each lane applies one of four output modes: delay, rising-edge pulse, retriggerable pulse stretch or toggle. It sits between top-level pins or loosely timed subsystems and the logic that consumes their signals.

## Interface
- NumChannels, 4, number of independent lanes (>= 1)
- Depth, 2, register stages before edge detection (>= 1)
- StretchCycles, 4, high time of a stretched pulse in cycles (>= 1)
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset; one clock; reset is asynchronous and active-low
- clear_i  input  1  synchronous clear of all lane state except the delay chain
- mode_i  input  2  global mode: 0 DELAY, 1 EDGE, 2 STRETCH, 3 TOGGLE
- sig_i  input  NumChannels  lane inputs
- sig_o  output  NumChannels  conditioned lane outputs, registered
- busy_o  output  NumChannels  lane stretch counter non-zero, registered

## Operation
- Per lane: delay chain d[0..Depth-1], d[0] <= sig_i[c], d[k] <= d[k-1]; s = d[Depth-1].
- Previous-value register p <= s; rise = s & ~p.
- Output register q drives sig_o[c]. Counter cnt drives busy_o[c] = (cnt != 0).
- cnt width is max(1, $clog2(StretchCycles)).
- Registered mode mode_q, reset 0 (DELAY). The lane update uses mode_q, never raw mode_i.
- DELAY: q <= s. cnt held at 0.
- EDGE: q <= rise. cnt held at 0.
- STRETCH:
  - on rise: q <= 1 and cnt <= StretchCycles-1 (retrigger restarts the window)
  - else if cnt != 0: q <= 1 and cnt <= cnt-1
  - else q <= 0
- TOGGLE: on rise q <= ~q; otherwise q holds. cnt held at 0.
- Mode change: when mode_i != mode_q, mode_q <= mode_i, and every lane has q <= 0 and cnt <= 0 that cycle. The new mode governs from the following cycle. d and p keep running.
- clear_i (priority below reset, above mode change): q <= 0 and cnt <= 0 in all lanes. mode_q still updates to mode_i. d and p keep running.
- Lanes are fully independent. No cross-lane arithmetic.

## Timing
- Reset (async assert, sync release by the system): d, p, q, cnt all 0; mode_q = DELAY. sig_o = 0 and busy_o = 0 immediately on assertion.
- If sig_i is high at reset release, it is treated as a rising edge once it reaches s.
- DELAY latency: sig_o follows sig_i after Depth+1 cycles.
- EDGE: a 0->1 on sig_i gives a one-cycle sig_o pulse Depth+1 cycles later. A level held high gives no further pulses.
- STRETCH timing:
  - sig_o rises Depth+1 cycles after the input edge and stays high exactly StretchCycles cycles if not retriggered.
  - busy_o is high for the first StretchCycles-1 of those cycles.
  - StretchCycles = 1 degenerates to EDGE behaviour with busy_o always 0.
  - A rise coincident with cnt = 1 or cnt = 0 restarts the full window with no low gap.
- TOGGLE: sig_o changes Depth+1 cycles after each rising input edge.
- Input pulses shorter than one cycle are not guaranteed to be captured. The block is not a CDC synchroniser unless Depth >= 2 and the integrator constrains it so.
- Reset mid-stretch: counter and output drop at once. After release there is no resumption; only a new rise restarts.
- Simultaneous clear_i and rise: clear wins for that cycle. The rise is lost because p updates regardless.

## Test plan
- Reset / DELAY: Depth=2, sig_i[0] goes 0->1 at cycle 10 -> sig_o[0] = 1 from cycle 13. All outputs 0 during reset, and 0 within the same cycle as async assertion mid-run.
- EDGE: mode 1, sig_i[1] high for cycles 10-20 -> sig_o[1] high only in cycle 13. A second rise at 25 -> pulse at 28.
- STRETCH with retrigger: StretchCycles=4, rises at cycles 10 and 12.
  - sig_o high 13..18 with no gap.
  - busy_o high 13..15 and 15..17, i.e. continuous 13..17.
  - A single rise gives sig_o high 13..16 and busy_o high 13..15.
- TOGGLE: mode 3, rises at 10, 20, 30 -> sig_o toggles at 13, 23, 33, ending at 1.
- Mode change: in STRETCH at cycle 14 with sig_o high, switch to DELAY -> sig_o = 0 and busy_o = 0 next cycle, then sig_o tracks s. Also covers clear_i coincident with a rise: no output pulse.
- Channel independence: NumChannels=4, random per-lane stimulus against a per-lane reference model in each mode. Repeat with Depth=1 and StretchCycles=1.

Source files
------------

// File: rtl/signal_conditioner.sv
// Multi-lane conditioner for slow control/status bits: per-lane delay chain and
// edge detector feeding an output stage selected by a registered global mode.
module signal_conditioner #(
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned Depth         = 2,
    parameter int unsigned StretchCycles = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [1:0]             mode_i,
    input  logic [NumChannels-1:0] sig_i,
    output logic [NumChannels-1:0] sig_o,
    output logic [NumChannels-1:0] busy_o
);

    localparam int unsigned CntW = (StretchCycles > 1) ? $clog2(StretchCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(StretchCycles - 1);

    typedef enum logic [1:0] {
        ModeDelay   = 2'd0,
        ModeEdge    = 2'd1,
        ModeStretch = 2'd2,
        ModeToggle  = 2'd3
    } mode_e;

    mode_e                  mode_q, mode_d;
    logic [NumChannels-1:0] dly_q [Depth];
    logic [NumChannels-1:0] prev_q;
    logic [NumChannels-1:0] q_q, q_d;
    logic [NumChannels-1:0] busy_q, busy_d;
    logic [CntW-1:0]        cnt_q [NumChannels];
    logic [CntW-1:0]        cnt_d [NumChannels];
    logic [NumChannels-1:0] s;
    logic [NumChannels-1:0] rise;
    logic                   flush;

    assign s     = dly_q[Depth-1];
    assign rise  = s & ~prev_q;
    // A mode change flushes the output stage exactly like a clear.
    assign flush = clear_i | (mode_i != mode_q);

    always_comb begin
        mode_d = mode_e'(mode_i);
        q_d    = q_q;
        busy_d = '0;
        for (int c = 0; c < NumChannels; c++) begin
            cnt_d[c] = cnt_q[c];
        end
        for (int c = 0; c < NumChannels; c++) begin
            if (flush) begin
                q_d[c]   = 1'b0;
                cnt_d[c] = '0;
            end else begin
                case (mode_q)
                    ModeDelay: begin
                        q_d[c]   = s[c];
                        cnt_d[c] = '0;
                    end
                    ModeEdge: begin
                        q_d[c]   = rise[c];
                        cnt_d[c] = '0;
                    end
                    ModeStretch: begin
                        // A retrigger reloads the full window with no low gap.
                        if (rise[c]) begin
                            q_d[c]   = 1'b1;
                            cnt_d[c] = CntLoad;
                        end else if (cnt_q[c] != '0) begin
                            q_d[c]   = 1'b1;
                            cnt_d[c] = cnt_q[c] - CntW'(1);
                        end else begin
                            q_d[c]   = 1'b0;
                        end
                    end
                    ModeToggle: begin
                        if (rise[c]) begin
                            q_d[c] = ~q_q[c];
                        end
                        cnt_d[c] = '0;
                    end
                    default: begin
                        q_d[c]   = 1'b0;
                        cnt_d[c] = '0;
                    end
                endcase
            end
            busy_d[c] = (cnt_d[c] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= ModeDelay;
            prev_q <= '0;
            q_q    <= '0;
            busy_q <= '0;
            for (int unsigned k = 0; k < Depth; k++) begin
                dly_q[k] <= '0;
            end
            for (int c = 0; c < NumChannels; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            mode_q   <= mode_d;
            prev_q   <= s;
            q_q      <= q_d;
            busy_q   <= busy_d;
            dly_q[0] <= sig_i;
            for (int unsigned k = 1; k < Depth; k++) begin
                dly_q[k] <= dly_q[k-1];
            end
            for (int c = 0; c < NumChannels; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign sig_o  = q_q;
    assign busy_o = busy_q;

endmodule
